// File: rtl/morse_decoder_core_if.sv
// Output-buffer side of the Morse decoder: write strobe, last character,
// fill level and the combinational random-access query used by the LCD.
interface morse_decoder_core_if #(
   parameter int OBUF_DEPTH = 16
);
   localparam int AW = $clog2(OBUF_DEPTH);

   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_char;
   logic [AW:0]   count;
   logic          char_valid;
   logic [7:0]    char_out;

   // Decoder drives the buffer view, the reader supplies the query index.
   modport master (
      input  rd_addr,
      output rd_char, count, char_valid, char_out
   );

   modport slave (
      output rd_addr,
      input  rd_char, count, char_valid, char_out
   );
endinterface

// File: rtl/morse_decoder_core.sv
// Morse decoder core: times key marks and gaps, classifies dit/dah, translates
// complete symbol patterns to ASCII and stores them in a circular buffer.
module morse_decoder_core #(
   parameter int MAX_SYMS   = 6,
   parameter int OBUF_DEPTH = 16,
   parameter int TIMER_W    = 32,
   parameter int OVERWRITE  = 1,
   parameter int WORD_SPACE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_pressed,
   input  logic                 clr,
   input  logic [TIMER_W-1:0]   dah_lim,
   input  logic [TIMER_W-1:0]   char_gap_lim,
   input  logic [TIMER_W-1:0]   word_gap_lim,
   morse_decoder_core_if.master obuf,
   output logic                 is_error,
   output logic                 overflow,
   output logic [2:0]           state_dbg
);
   localparam int AW = $clog2(OBUF_DEPTH);
   localparam int LW = $clog2(MAX_SYMS + 1);
   localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_SYMS);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(OBUF_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MARK  = 3'd1,
      ST_GAP   = 3'd2,
      ST_TRANS = 3'd3,
      ST_WORD  = 3'd4
   } state_t;

   state_t                state_reg, state_next;
   logic [TIMER_W-1:0]    mark_timer_reg, mark_timer_next;
   logic [TIMER_W-1:0]    gap_timer_reg, gap_timer_next;
   logic [LW-1:0]         ibuf_len_reg, ibuf_len_next;
   logic [MAX_SYMS-1:0]   ibuf_bits_reg, ibuf_bits_next;
   logic                  sym_ovf_reg, sym_ovf_next;
   logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
   logic [AW:0]           count_reg, count_next;
   logic                  char_valid_reg, char_valid_next;
   logic [7:0]            char_out_reg, char_out_next;
   logic                  is_error_reg, is_error_next;
   logic                  overflow_reg, overflow_next;

   logic                  wr_req;
   logic [7:0]            wr_data;
   logic                  mem_we;
   logic                  sym;
   logic                  full;
   logic [7:0]            lookup_code;
   logic [AW-1:0]         rd_phys;
   logic [7:0]            obuf_mem [OBUF_DEPTH];

   // Pattern key is {length, symbols}; bit 0 is the first symbol, 1 = dah.
   // Unused upper symbol bits are always zero, so the key is exact.
   function automatic logic [7:0] morse_lookup(input logic [LW-1:0] len,
                                               input logic [MAX_SYMS-1:0] bits);
      logic [15:0] key;
      key = {8'(len), 8'(bits)};
      case (key)
         {8'd1, 8'b0}:     morse_lookup = 8'h45; // E
         {8'd1, 8'b1}:     morse_lookup = 8'h54; // T
         {8'd2, 8'b10}:    morse_lookup = 8'h41; // A
         {8'd2, 8'b00}:    morse_lookup = 8'h49; // I
         {8'd2, 8'b11}:    morse_lookup = 8'h4D; // M
         {8'd2, 8'b01}:    morse_lookup = 8'h4E; // N
         {8'd3, 8'b001}:   morse_lookup = 8'h44; // D
         {8'd3, 8'b011}:   morse_lookup = 8'h47; // G
         {8'd3, 8'b101}:   morse_lookup = 8'h4B; // K
         {8'd3, 8'b111}:   morse_lookup = 8'h4F; // O
         {8'd3, 8'b010}:   morse_lookup = 8'h52; // R
         {8'd3, 8'b000}:   morse_lookup = 8'h53; // S
         {8'd3, 8'b100}:   morse_lookup = 8'h55; // U
         {8'd3, 8'b110}:   morse_lookup = 8'h57; // W
         {8'd4, 8'b0001}:  morse_lookup = 8'h42; // B
         {8'd4, 8'b0101}:  morse_lookup = 8'h43; // C
         {8'd4, 8'b0100}:  morse_lookup = 8'h46; // F
         {8'd4, 8'b0000}:  morse_lookup = 8'h48; // H
         {8'd4, 8'b1110}:  morse_lookup = 8'h4A; // J
         {8'd4, 8'b0010}:  morse_lookup = 8'h4C; // L
         {8'd4, 8'b0110}:  morse_lookup = 8'h50; // P
         {8'd4, 8'b1011}:  morse_lookup = 8'h51; // Q
         {8'd4, 8'b1000}:  morse_lookup = 8'h56; // V
         {8'd4, 8'b1001}:  morse_lookup = 8'h58; // X
         {8'd4, 8'b1101}:  morse_lookup = 8'h59; // Y
         {8'd4, 8'b0011}:  morse_lookup = 8'h5A; // Z
         {8'd5, 8'b11111}: morse_lookup = 8'h30; // 0
         {8'd5, 8'b11110}: morse_lookup = 8'h31; // 1
         {8'd5, 8'b11100}: morse_lookup = 8'h32; // 2
         {8'd5, 8'b11000}: morse_lookup = 8'h33; // 3
         {8'd5, 8'b10000}: morse_lookup = 8'h34; // 4
         {8'd5, 8'b00000}: morse_lookup = 8'h35; // 5
         {8'd5, 8'b00001}: morse_lookup = 8'h36; // 6
         {8'd5, 8'b00011}: morse_lookup = 8'h37; // 7
         {8'd5, 8'b00111}: morse_lookup = 8'h38; // 8
         {8'd5, 8'b01111}: morse_lookup = 8'h39; // 9
         default:          morse_lookup = 8'h00; // no entry
      endcase
   endfunction

   assign lookup_code = morse_lookup(ibuf_len_reg, ibuf_bits_reg);
   assign sym         = (mark_timer_reg >= dah_lim);
   assign full        = (count_reg == CNT_FULL);

   // State register and all datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         mark_timer_reg <= '0;
         gap_timer_reg  <= '0;
         ibuf_len_reg   <= '0;
         ibuf_bits_reg  <= '0;
         sym_ovf_reg    <= 1'b0;
         wr_ptr_reg     <= '0;
         count_reg      <= '0;
         char_valid_reg <= 1'b0;
         char_out_reg   <= 8'h00;
         is_error_reg   <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         mark_timer_reg <= mark_timer_next;
         gap_timer_reg  <= gap_timer_next;
         ibuf_len_reg   <= ibuf_len_next;
         ibuf_bits_reg  <= ibuf_bits_next;
         sym_ovf_reg    <= sym_ovf_next;
         wr_ptr_reg     <= wr_ptr_next;
         count_reg      <= count_next;
         char_valid_reg <= char_valid_next;
         char_out_reg   <= char_out_next;
         is_error_reg   <= is_error_next;
         overflow_reg   <= overflow_next;
      end
   end

   // Next-state, timers, symbol assembly and buffer write decision.
   always_comb begin
      state_next      = state_reg;
      mark_timer_next = mark_timer_reg;
      gap_timer_next  = gap_timer_reg;
      ibuf_len_next   = ibuf_len_reg;
      ibuf_bits_next  = ibuf_bits_reg;
      sym_ovf_next    = sym_ovf_reg;
      wr_ptr_next     = wr_ptr_reg;
      count_next      = count_reg;
      char_valid_next = 1'b0;
      char_out_next   = char_out_reg;
      is_error_next   = is_error_reg;
      overflow_next   = overflow_reg;
      wr_req          = 1'b0;
      wr_data         = 8'h00;
      mem_we          = 1'b0;

      if (clr) begin
         state_next      = ST_IDLE;
         mark_timer_next = '0;
         gap_timer_next  = '0;
         ibuf_len_next   = '0;
         ibuf_bits_next  = '0;
         sym_ovf_next    = 1'b0;
         wr_ptr_next     = '0;
         count_next      = '0;
         char_out_next   = 8'h00;
         is_error_next   = 1'b0;
         overflow_next   = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (key_pressed) begin
                  state_next      = ST_MARK;
                  mark_timer_next = TIMER_W'(1);
               end
            end
            ST_MARK: begin
               if (key_pressed) begin
                  if (mark_timer_reg != '1)
                     mark_timer_next = mark_timer_reg + 1'b1;
               end else begin
                  if (ibuf_len_reg < MAX_LEN) begin
                     for (int i = 0; i < MAX_SYMS; i++)
                        if (i == int'(ibuf_len_reg))
                           ibuf_bits_next[i] = sym;
                     ibuf_len_next = ibuf_len_reg + 1'b1;
                  end else begin
                     sym_ovf_next = 1'b1;
                  end
                  state_next     = ST_GAP;
                  gap_timer_next = TIMER_W'(1);
               end
            end
            ST_GAP: begin
               if (key_pressed) begin
                  state_next      = ST_MARK;
                  mark_timer_next = TIMER_W'(1);
               end else begin
                  if (gap_timer_reg != '1)
                     gap_timer_next = gap_timer_reg + 1'b1;
                  if (gap_timer_reg == char_gap_lim)
                     state_next = ST_TRANS;
               end
            end
            ST_TRANS: begin
               // Key is deliberately ignored here; WORD samples it next cycle.
               wr_req = 1'b1;
               if (sym_ovf_reg || lookup_code == 8'h00) begin
                  wr_data       = 8'h3F;
                  is_error_next = 1'b1;
               end else begin
                  wr_data = lookup_code;
               end
               ibuf_len_next  = '0;
               ibuf_bits_next = '0;
               sym_ovf_next   = 1'b0;
               if (gap_timer_reg != '1)
                  gap_timer_next = gap_timer_reg + 1'b1;
               state_next = ST_WORD;
            end
            ST_WORD: begin
               if (key_pressed) begin
                  state_next      = ST_MARK;
                  mark_timer_next = TIMER_W'(1);
               end else begin
                  if (gap_timer_reg != '1)
                     gap_timer_next = gap_timer_reg + 1'b1;
                  if (gap_timer_reg == word_gap_lim) begin
                     wr_req     = (WORD_SPACE != 0);
                     wr_data    = 8'h20;
                     state_next = ST_IDLE;
                  end
               end
            end
            default: state_next = ST_IDLE;
         endcase

         // When full, overwrite mode advances wr_ptr with count pinned at
         // depth, which implicitly moves the oldest entry forward.
         if (wr_req) begin
            if (full)
               overflow_next = 1'b1;
            if (!full || OVERWRITE != 0) begin
               mem_we          = 1'b1;
               wr_ptr_next     = wr_ptr_reg + 1'b1;
               char_valid_next = 1'b1;
               char_out_next   = wr_data;
               if (!full)
                  count_next = count_reg + 1'b1;
            end
         end
      end
   end

   // Character storage; contents need no reset because count gates reads.
   always_ff @(posedge clk) begin
      if (mem_we)
         obuf_mem[wr_ptr_reg] <= wr_data;
   end

   // When full, count[AW-1:0] is zero and the oldest entry sits at wr_ptr.
   assign rd_phys         = wr_ptr_reg - count_reg[AW-1:0] + obuf.rd_addr;
   assign obuf.rd_char    = ({1'b0, obuf.rd_addr} < count_reg) ? obuf_mem[rd_phys] : 8'h00;
   assign obuf.count      = count_reg;
   assign obuf.char_valid = char_valid_reg;
   assign obuf.char_out   = char_out_reg;
   assign is_error        = is_error_reg;
   assign overflow        = overflow_reg;
   assign state_dbg       = state_reg;
endmodule

// File: tb/tb_morse_decoder_core.sv
// Directed bench for morse_decoder_core: three instances share one key stream
// (depth 16 default, depth 4 overwrite without word spaces, depth 4 drop).
module tb_morse_decoder_core;
   logic        clk;
   logic        rst;
   logic        key_pressed;
   logic        clr;
   logic [31:0] dah_lim, char_gap_lim, word_gap_lim;
   logic        is_error0, overflow0, is_error1, overflow1, is_error2, overflow2;
   logic [2:0]  state0, state1, state2;
   int          n_checks = 0;
   int          n_errors = 0;

   morse_decoder_core_if #(.OBUF_DEPTH(16)) bus0 ();
   morse_decoder_core_if #(.OBUF_DEPTH(4))  bus1 ();
   morse_decoder_core_if #(.OBUF_DEPTH(4))  bus2 ();

   morse_decoder_core #(.MAX_SYMS(6), .OBUF_DEPTH(16), .TIMER_W(32),
                        .OVERWRITE(1), .WORD_SPACE(1)) dut0 (
      .clk(clk), .rst(rst), .key_pressed(key_pressed), .clr(clr),
      .dah_lim(dah_lim), .char_gap_lim(char_gap_lim), .word_gap_lim(word_gap_lim),
      .obuf(bus0), .is_error(is_error0), .overflow(overflow0), .state_dbg(state0)
   );

   morse_decoder_core #(.MAX_SYMS(6), .OBUF_DEPTH(4), .TIMER_W(32),
                        .OVERWRITE(1), .WORD_SPACE(0)) dut1 (
      .clk(clk), .rst(rst), .key_pressed(key_pressed), .clr(clr),
      .dah_lim(dah_lim), .char_gap_lim(char_gap_lim), .word_gap_lim(word_gap_lim),
      .obuf(bus1), .is_error(is_error1), .overflow(overflow1), .state_dbg(state1)
   );

   morse_decoder_core #(.MAX_SYMS(6), .OBUF_DEPTH(4), .TIMER_W(32),
                        .OVERWRITE(0), .WORD_SPACE(1)) dut2 (
      .clk(clk), .rst(rst), .key_pressed(key_pressed), .clr(clr),
      .dah_lim(dah_lim), .char_gap_lim(char_gap_lim), .word_gap_lim(word_gap_lim),
      .obuf(bus2), .is_error(is_error2), .overflow(overflow2), .state_dbg(state2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are read 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [3:0] a);
      bus0.rd_addr = a;
      bus1.rd_addr = a[1:0];
      bus2.rd_addr = a[1:0];
      #1;
   endtask

   // Dit = 1 cycle high, dah = 4 cycles high, 2 low cycles between symbols.
   task automatic send_char(input string pat);
      for (int i = 0; i < pat.len(); i++) begin
         key_pressed = 1'b1;
         repeat ((pat[i] == "-") ? 4 : 1) tick();
         key_pressed = 1'b0;
         if (i != pat.len() - 1)
            repeat (2) tick();
      end
   endtask

   task automatic wait_char(input string tag);
      int n = 0;
      while (!bus0.char_valid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(bus0.char_valid), 32'd1);
      $display("tb: %s char_out=%02h count=%0d", tag, bus0.char_out, bus0.count);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; key_pressed = 1'b0;
      dah_lim = 32'd3; char_gap_lim = 32'd5; word_gap_lim = 32'd12;
      bus0.rd_addr = '0; bus1.rd_addr = '0; bus2.rd_addr = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_state", 32'(state0), 32'd0);
      chk("rst_count", 32'(bus0.count), 32'd0);
      chk("rst_valid", 32'(bus0.char_valid), 32'd0);
      chk("rst_cout", 32'(bus0.char_out), 32'd0);
      chk("rst_err", 32'(is_error0), 32'd0);
      chk("rst_ovf", 32'(overflow0), 32'd0);
      set_rd(4'd0);
      chk("rst_rd0", 32'(bus0.rd_char), 32'd0);

      // 'A': mark 1, gap 2, mark 4, release
      key_pressed = 1'b1; tick();
      key_pressed = 1'b0; repeat (2) tick();
      key_pressed = 1'b1; repeat (4) tick();
      key_pressed = 1'b0; tick();
      chk("a_gap", 32'(state0), 32'd2);
      repeat (4) tick();
      chk("a_gap5", 32'(state0), 32'd2);
      tick();
      chk("a_trans", 32'(state0), 32'd3);
      chk("a_trans_nov", 32'(bus0.char_valid), 32'd0);
      tick();
      $display("tb: A char_out=%02h count=%0d", bus0.char_out, bus0.count);
      chk("a_valid", 32'(bus0.char_valid), 32'd1);
      chk("a_cout", 32'(bus0.char_out), 32'h41);
      chk("a_count", 32'(bus0.count), 32'd1);
      chk("a_state", 32'(state0), 32'd4);
      set_rd(4'd0);
      chk("a_rd0", 32'(bus0.rd_char), 32'h41);
      chk("a_err", 32'(is_error0), 32'd0);

      // Word gap: space written when gap reaches 12
      repeat (5) tick();
      chk("w_pre_state", 32'(state0), 32'd4);
      chk("w_pre_count", 32'(bus0.count), 32'd1);
      tick();
      $display("tb: SPACE char_out=%02h count=%0d", bus0.char_out, bus0.count);
      chk("w_valid", 32'(bus0.char_valid), 32'd1);
      chk("w_cout", 32'(bus0.char_out), 32'h20);
      chk("w_count", 32'(bus0.count), 32'd2);
      chk("w_state", 32'(state0), 32'd0);
      set_rd(4'd1);
      chk("w_rd1", 32'(bus0.rd_char), 32'h20);
      chk("w_rd1_oob", 32'(bus1.rd_char), 32'h00);
      chk("ns_valid", 32'(bus1.char_valid), 32'd0);
      chk("ns_count", 32'(bus1.count), 32'd1);
      chk("ns_state", 32'(state1), 32'd0);

      // clr mid-GAP
      key_pressed = 1'b1; tick();
      key_pressed = 1'b0; repeat (2) tick();
      chk("c_in_gap", 32'(state0), 32'd2);
      clr = 1'b1; tick();
      clr = 1'b0;
      chk("c_state", 32'(state0), 32'd0);
      chk("c_count", 32'(bus0.count), 32'd0);
      chk("c_cout", 32'(bus0.char_out), 32'd0);
      chk("c_count2", 32'(bus2.count), 32'd0);
      tick();

      // Buffer full handling: E,T,A,N,I
      send_char(".");    wait_char("E"); chk("e_cout", 32'(bus0.char_out), 32'h45);
      send_char("-");    wait_char("T"); chk("t_cout", 32'(bus0.char_out), 32'h54);
      send_char(".-");   wait_char("A"); chk("a2_cout", 32'(bus0.char_out), 32'h41);
      send_char("-.");   wait_char("N"); chk("n_cout", 32'(bus0.char_out), 32'h4E);
      chk("n_ovf1", 32'(overflow1), 32'd0);
      send_char("..");   wait_char("I"); chk("i_cout", 32'(bus0.char_out), 32'h49);
      chk("i_valid_ow", 32'(bus1.char_valid), 32'd1);
      chk("i_valid_drop", 32'(bus2.char_valid), 32'd0);
      chk("ow_count", 32'(bus1.count), 32'd4);
      chk("ow_ovf", 32'(overflow1), 32'd1);
      chk("dr_count", 32'(bus2.count), 32'd4);
      chk("dr_ovf", 32'(overflow2), 32'd1);
      chk("big_count", 32'(bus0.count), 32'd5);
      chk("big_ovf", 32'(overflow0), 32'd0);
      set_rd(4'd0);
      chk("ow_rd0", 32'(bus1.rd_char), 32'h54);
      chk("dr_rd0", 32'(bus2.rd_char), 32'h45);
      set_rd(4'd3);
      chk("ow_rd3", 32'(bus1.rd_char), 32'h49);
      chk("dr_rd3", 32'(bus2.rd_char), 32'h4E);
      set_rd(4'd4);
      chk("big_rd4", 32'(bus0.rd_char), 32'h49);

      // Seven dits: symbol overflow gives '?', next char is normal
      send_char("......."); wait_char("OVF");
      chk("so_cout", 32'(bus0.char_out), 32'h3F);
      chk("so_err", 32'(is_error0), 32'd1);
      send_char("-"); wait_char("T2");
      chk("so_next", 32'(bus0.char_out), 32'h54);

      // Six-symbol pattern with no table entry
      clr = 1'b1; tick();
      clr = 1'b0;
      chk("c2_err", 32'(is_error0), 32'd0);
      send_char(".-.-.-"); wait_char("MISS");
      chk("mi_cout", 32'(bus0.char_out), 32'h3F);
      chk("mi_err", 32'(is_error0), 32'd1);
      chk("mi_count", 32'(bus0.count), 32'd1);

      // Asynchronous reset mid-MARK
      key_pressed = 1'b1; repeat (2) tick();
      chk("r_in_mark", 32'(state0), 32'd1);
      rst = 1'b1;
      #1;
      chk("r_state", 32'(state0), 32'd0);
      chk("r_count", 32'(bus0.count), 32'd0);
      chk("r_err", 32'(is_error0), 32'd0);
      chk("r_cout", 32'(bus0.char_out), 32'd0);
      key_pressed = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      send_char("-.."); wait_char("D");
      chk("d_cout", 32'(bus0.char_out), 32'h44);
      chk("d_count", 32'(bus0.count), 32'd1);
      set_rd(4'd0);
      chk("d_rd0", 32'(bus0.rd_char), 32'h44);
      chk("d_err", 32'(is_error0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
